wrr_arbiter: RTL

Registered, parametrised weighted round-robin arbiter for WIDTH requestors. It selects one winner per arbitration, holds the grant for a per-requestor number of cycles (weighted mode) or while lock is held, then rotates priority to the bit after the last winner. It sits in front of shared resources (bus ports, memory banks) where grant must be a clean flop output and fairness must be tunable.

---
 rtl/wrr_arbiter_pkg.sv | 40 ++++
 rtl/wrr_arbiter_if.sv | 24 ++
 rtl/wrr_arbiter_fixed.sv | 16 +
 rtl/wrr_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Helpers work on a fixed maximum width; callers truncate to their own WIDTH.
package arb_pkg;

   localparam int ARB_MAX_W   = 64;
   localparam int ARB_MAX_IDW = 6;

   typedef enum logic {
      ARB_RR  = 1'b0,
      ARB_WRR = 1'b1
   } arb_mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } arb_state_e;

   function automatic logic [ARB_MAX_IDW-1:0] onehot2bin(input logic [ARB_MAX_W-1:0] v);
      logic [ARB_MAX_IDW-1:0] b;
      b = '0;
      for (int i = 0; i < ARB_MAX_W; i++) begin
         if (v[i]) b = b | ARB_MAX_IDW'(i);
      end
      return b;
   endfunction

   // Rotates a one-hot vector left by one within the low w bits.
   function automatic logic [ARB_MAX_W-1:0] rotl1(input logic [ARB_MAX_W-1:0] v, input int w);
      logic [ARB_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < ARB_MAX_W; i++) begin
         if (i < w) begin
            if (i == w - 1) r[0] = v[i];
            else            r[i+1] = v[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between requestors and the weighted round-robin arbiter.
interface wrr_arbiter_if #(
   parameter  int WIDTH = 8,
   parameter  int CW    = 4,
   localparam int IDW   = $clog2(WIDTH)
);
   logic [WIDTH-1:0]    req;
   logic [WIDTH*CW-1:0] weight;
   logic                mode;
   logic                lock;
   logic [WIDTH-1:0]    grant;
   logic                grant_valid;
   logic [IDW-1:0]      grant_id;

   modport master (
      output req, weight, mode, lock,
      input  grant, grant_valid, grant_id
   );

   modport slave (
      input  req, weight, mode, lock,
      output grant, grant_valid, grant_id
   );
endinterface

// File: rtl/wrr_arbiter_fixed.sv
// Combinational fixed-priority pick starting at a one-hot base, wrapping at the top.
module fixed_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] req,
   input  logic [WIDTH-1:0] base,
   output logic [WIDTH-1:0] grant
);
   logic [2*WIDTH-1:0] dreq;
   logic [2*WIDTH-1:0] dgnt;

   // Doubling the request vector turns the wrap-around search into a plain borrow chain.
   assign dreq  = {req, req};
   assign dgnt  = dreq & ~(dreq - {{WIDTH{1'b0}}, base});
   assign grant = dgnt[WIDTH-1:0] | dgnt[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/wrr_arbiter.sv
// Registered weighted round-robin arbiter; grant is held for a credit burst or under lock.
//
// state    | meaning
// ST_IDLE  | grant_valid=0, nobody owns the resource
// ST_OWNED | grant_valid=1, grant_id owns it; credit counts down the burst
module wrr_arbiter
   import arb_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int CW    = 4,
   localparam int IDW   = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   wrr_arbiter_if.slave  bus
);

   logic [WIDTH-1:0] ptr_q,   ptr_d;
   logic [WIDTH-1:0] grant_q, grant_d;
   logic [IDW-1:0]   id_q,    id_d;
   logic             valid_q, valid_d;
   logic [CW-1:0]    credit_q, credit_d;

   logic [WIDTH-1:0] winner;
   logic [IDW-1:0]   win_id;
   logic [CW-1:0]    win_weight;
   arb_state_e       state;
   logic             wrr_active;
   logic             keep;

   fixed_arbiter #(.WIDTH(WIDTH)) u_pick (
      .req   (bus.req),
      .base  (ptr_q),
      .grant (winner)
   );

   assign state      = arb_state_e'(valid_q);
   assign win_id     = IDW'(onehot2bin(ARB_MAX_W'(winner)));
   assign win_weight = bus.weight[int'(win_id)*CW +: CW];
   assign wrr_active = (arb_mode_e'(bus.mode) == ARB_WRR) && (credit_q > CW'(1));
   assign keep       = (state == ST_OWNED) && bus.req[id_q] && (bus.lock || wrr_active);

   always_comb begin
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      id_d     = id_q;
      valid_d  = valid_q;
      credit_d = credit_q;
      if (keep) begin
         // Under lock the credit parks at 1 so release re-arbitrates immediately.
         if (credit_q > CW'(1)) credit_d = credit_q - CW'(1);
      end else if (|bus.req) begin
         grant_d  = winner;
         id_d     = win_id;
         valid_d  = 1'b1;
         credit_d = (win_weight == '0) ? CW'(1) : win_weight;
         ptr_d    = WIDTH'(rotl1(ARB_MAX_W'(winner), WIDTH));
      end else begin
         grant_d = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= WIDTH'(1);
         grant_q  <= '0;
         id_q     <= '0;
         valid_q  <= 1'b0;
         credit_q <= '0;
      end else begin
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         id_q     <= id_d;
         valid_q  <= valid_d;
         credit_q <= credit_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_valid = valid_q;
   assign bus.grant_id    = id_q;

endmodule
